simple_tx_arbiter: RTL and testbench
====================================

// Module: simple_tx_arbiter
//
// PURPOSE
//   Shares one simple_tx UART transmitter between num_req byte-stream sources (simple_message-style producers).
//   Round-robin, packet-locked arbitration: a grant holds until the source's 'last' beat or max_len bytes.
//   Optionally emits a 1-byte source-ID header so a downstream simple_rx/sink can demultiplex.
//   Sits between the producers and simple_tx._in/_in_valid/_in_ready in a top like simple_top.
//
// PARAMETERS
//   num_req    4   number of requesting sources, 2..8
//   max_len    16  max payload bytes per grant before forced release, 1..255
//   header_en  1   1 = send header byte 8'hA0|id before each payload, 0 = payload only
//
// PORTS
//   _clock      in   1          single clock, all state on rising edge
//   _reset      in   1          synchronous, active-high
//   _in         in   num_req*8  source data, byte i at [8*i+7:8*i]
//   _in_valid   in   num_req    per-source valid
//   _in_last    in   num_req    per-source end-of-packet, qualified by valid
//   _in_ready   out  num_req    per-source ready, at most one bit high
//   _out        out  8          byte to simple_tx._in
//   _out_valid  out  1          to simple_tx._in_valid
//   _out_ready  in   1          from simple_tx._in_ready
//   _grant_id   out  3          index of current/last owner (debug/status)
//   _busy       out  1          1 while state != IDLE
//
// BEHAVIOUR
//   - Transfer = valid & ready on a rising edge. Once valid is high, _out/_out_valid hold until accepted.
//   - Reset: state=IDLE, rr_ptr=num_req-1 (req 0 wins first), len_cnt=0.
//     Outputs at reset: _out_valid=0, _in_ready=0, _out=0, _grant_id=0, _busy=0.
//   - IDLE: if any _in_valid, pick first set bit scanning from rr_ptr+1 mod num_req.
//     Latch grant=pick and rr_ptr=pick, len_cnt=0. Go HEADER if header_en, else PAYLOAD.
//     Arbitration costs 1 cycle; nothing is transferred in IDLE.
//   - HEADER: _out=8'hA0|grant, _out_valid=1, _in_ready=0. On _out_ready go PAYLOAD.
//   - PAYLOAD: combinational passthrough of the granted source, zero added latency:
//     _out=_in[grant], _out_valid=_in_valid[grant], _in_ready[grant]=_out_ready, other ready bits 0.
//     On each transfer, len_cnt++. Go IDLE when the beat has _in_last=1 or len_cnt+1==max_len.
//   - Source drops valid mid-packet: grant is held and _out_valid=0 until it resumes. There is no timeout.
//   - Forced release at max_len without last: the remainder re-arbitrates as a new packet (new header).
//   - Simultaneous last and max_len on the same beat: a single release; no extra state.
//   - Non-granted sources' valid/data are ignored; their _in_ready stays 0.
//   - Reset mid-packet: abort the packet immediately, return to reset values. A partial byte stream on the line is acceptable.
//   - len_cnt is 8 bits and saturates unreachable by construction (max_len<=255).
//   - _grant_id is registered: it updates on the grant cycle and holds through IDLE.
//
// STRUCTURE
//   - simple_arb_pkg: arb_state_t enum {IDLE, HEADER, PAYLOAD}, HDR_TAG=4'hA, function hdr_byte(id).
//   - Sub-module rr_pick #(num_req): combinational; inputs req vector and ptr, outputs pick and any.
//     Used once here and reusable elsewhere.
//   - Top-level FSM plus output mux live in simple_tx_arbiter; no internal FIFO.
//
// TESTING
//   1. Reset, then src0 sends 3 bytes 11,22,33 (last on 33), header_en=1, _out_ready=1.
//      -> _out = A0,11,22,33; 1 IDLE cycle first; _busy drops after 33.
//   2. All 4 sources hold 1-byte packets continuously.
//      -> grant order 0,1,2,3,0,...; headers A0,A1,A2,A3; no source starved.
//   3. src2 sends 20 bytes without last, max_len=16.
//      -> A2+16 bytes, IDLE, then A2+4 bytes (if alone). Len counts are exact.
//   4. _out_ready low for 5 cycles during HEADER, then during PAYLOAD.
//      -> _out stable and _in_ready[grant]=0 throughout. No byte lost or duplicated.
//   5. Assert _reset mid-PAYLOAD of src1.
//      -> next cycle _out_valid=0 and all _in_ready=0; the next grant goes to src0 if it is valid.
//   6. header_en=0 with src3 and src1 one byte each, same cycle.
//      -> bytes emitted src0-first scan order: src1 then src3; no header bytes.
//   Also: end-to-end in simple_top with simple_tx/simple_rx. The sink must observe the identical header+payload sequence.

Source files
------------

// File: rtl/simple_arb_pkg.sv
// Shared types and helpers for the round-robin UART transmit arbiter.
package simple_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } arb_state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Header byte tagging a packet with its source index: 8'hA0 | id.
    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {HDR_TAG, 1'b0, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping.
module rr_pick #(
    parameter int num_req = 4
) (
    input  logic [num_req-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         pick,
    output logic               any
);

    // Scan farthest-first so the nearest candidate after ptr overwrites the rest.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = num_req; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % num_req]) begin
                pick = 3'((int'(ptr) + k) % num_req);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one byte-wide transmitter among num_req sources,
// with an optional per-packet source-ID header byte.
module simple_tx_arbiter
    import simple_arb_pkg::*;
#(
    parameter int num_req   = 4,
    parameter int max_len   = 16,
    parameter int header_en = 1
) (
    input  logic                 _clock,
    input  logic                 _reset,
    input  logic [num_req*8-1:0] _in,
    input  logic [num_req-1:0]   _in_valid,
    input  logic [num_req-1:0]   _in_last,
    output logic [num_req-1:0]   _in_ready,
    output logic [7:0]           _out,
    output logic                 _out_valid,
    input  logic                 _out_ready,
    output logic [2:0]           _grant_id,
    output logic                 _busy
);

    localparam logic [8:0] MAX_LEN_W = 9'(max_len);

    arb_state_t state, state_n;
    logic [2:0] grant, grant_n;
    logic [2:0] rr_ptr, rr_ptr_n;
    logic [7:0] len_cnt, len_cnt_n;

    logic [2:0]  pick;
    logic        any;
    logic [7:0]  valid_pad, last_pad, ready_pad;
    logic [63:0] data_pad;
    logic        g_valid, g_last;
    logic [7:0]  g_data;

    rr_pick #(.num_req(num_req)) u_pick (
        .req  (_in_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    // Pad source vectors to the full 8-source width so a 3-bit grant always indexes in range.
    assign valid_pad = 8'(_in_valid);
    assign last_pad  = 8'(_in_last);
    assign data_pad  = 64'(_in);
    assign g_valid   = valid_pad[grant];
    assign g_last    = last_pad[grant];
    assign g_data    = data_pad[{grant, 3'b000} +: 8];

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= 3'(num_req - 1);
            len_cnt <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            rr_ptr  <= rr_ptr_n;
            len_cnt <= len_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        len_cnt_n  = len_cnt;
        _out       = '0;
        _out_valid = 1'b0;
        ready_pad  = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_n   = pick;
                    rr_ptr_n  = pick;
                    len_cnt_n = '0;
                    if (header_en != 0) state_n = HEADER;
                    else                state_n = PAYLOAD;
                end
            end
            HEADER: begin
                _out       = hdr_byte(grant);
                _out_valid = 1'b1;
                if (_out_ready) state_n = PAYLOAD;
            end
            PAYLOAD: begin
                _out       = g_data;
                _out_valid = g_valid;
                if (_out_ready) ready_pad = 8'b1 << grant;
                if (g_valid && _out_ready) begin
                    if (len_cnt != 8'hFF) len_cnt_n = len_cnt + 8'd1;
                    // Packet end and length cap on the same beat collapse into one release.
                    if (g_last || ({1'b0, len_cnt} + 9'd1 == MAX_LEN_W)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign _in_ready = ready_pad[num_req-1:0];
    assign _grant_id = grant;
    assign _busy     = (state != IDLE);

endmodule

// File: tb/tb_simple_tx_arbiter.sv
// Directed bench for simple_tx_arbiter: header and header-less instances driven by per-source byte queues.
module tb_simple_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last;
    logic        out_ready;
    logic        sel;

    logic [3:0] valid_a, valid_b, ready_a, ready_b;
    logic [7:0] out_a, out_b;
    logic       ov_a, ov_b, busy_a, busy_b;
    logic [2:0] gid_a, gid_b;

    logic [3:0] o_ready;
    logic [7:0] o_out;
    logic       o_valid, o_busy;
    logic [2:0] o_gid;

    assign valid_a = in_valid & {4{~sel}};
    assign valid_b = in_valid & {4{sel}};
    assign o_ready = sel ? ready_b : ready_a;
    assign o_out   = sel ? out_b : out_a;
    assign o_valid = sel ? ov_b : ov_a;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_gid   = sel ? gid_b : gid_a;

    simple_tx_arbiter #(.num_req(4), .max_len(16), .header_en(1)) dut (
        ._clock(clk), ._reset(rst), ._in(in_data), ._in_valid(valid_a), ._in_last(in_last),
        ._in_ready(ready_a), ._out(out_a), ._out_valid(ov_a), ._out_ready(out_ready),
        ._grant_id(gid_a), ._busy(busy_a)
    );

    simple_tx_arbiter #(.num_req(4), .max_len(16), .header_en(0)) dut_nh (
        ._clock(clk), ._reset(rst), ._in(in_data), ._in_valid(valid_b), ._in_last(in_last),
        ._in_ready(ready_b), ._out(out_b), ._out_valid(ov_b), ._out_ready(out_ready),
        ._grant_id(gid_b), ._busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0] smem [4][32];
    int         head [4];
    int         tail [4];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic       rst_q, rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        smem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    // One cycle: drive at negedge, sample after settling, posedge commits.
    task automatic step();
        @(negedge clk);
        rst       = rst_q;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]        = (head[i] != tail[i]);
            in_data[i*8 +: 8]  = in_valid[i] ? smem[i][head[i]][7:0] : 8'h00;
            in_last[i]         = in_valid[i] ? smem[i][head[i]][8] : 1'b0;
        end
        #1;
        if (o_valid && out_ready) got.push_back(o_out);
        for (int i = 0; i < 4; i++)
            if (o_ready[i] && in_valid[i]) head[i]++;
    endtask

    task automatic do_reset();
        rst_q = 1'b1;
        step();
        step();
        rst_q = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        got.delete();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) step();
        chk(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic cmp_got(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    initial begin
        sel = 1'b0; rdy = 1'b1; rst_q = 1'b1;
        rst = 1'b1; out_ready = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset state
        step();
        step();
        chk("rst_ov",   32'(o_valid), 0);
        chk("rst_rdy",  32'(o_ready), 0);
        chk("rst_out",  32'(o_out),   0);
        chk("rst_gid",  32'(o_gid),   0);
        chk("rst_busy", 32'(o_busy),  0);

        // 1: src0 sends 11,22,33 with one arbitration cycle first
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        step();
        chk("t1_idle", {o_valid, o_busy}, 0);
        step();
        chk("t1_hdr", {o_valid, o_busy, o_ready, o_out}, {2'b11, 4'b0000, 8'hA0});
        step();
        chk("t1_b0", {o_valid, o_ready, o_out}, {1'b1, 4'b0001, 8'h11});
        step();
        step();
        step();
        chk("t1_done", {o_valid, o_busy}, 0);
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        chk("t1_len", 32'(got.size()), 4);
        cmp_got("t1_seq");

        // 2: all four sources with back-to-back 1-byte packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) push(s, 8'((s + 1) * 16 + r), 1);
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) begin
                exp_q.push_back(8'hA0 | 8'(s));
                exp_q.push_back(8'((s + 1) * 16 + r));
            end
        run_until("t2_len", 16, 60);
        cmp_got("t2_seq");

        // 3: src2 sends 20 bytes, forced release after 16, remainder re-headed
        do_reset();
        for (int b = 1; b <= 20; b++) push(2, 8'(b), b == 20);
        exp_q.delete();
        exp_q.push_back(8'hA2);
        for (int b = 1; b <= 16; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'hA2);
        for (int b = 17; b <= 20; b++) exp_q.push_back(8'(b));
        run_until("t3_len", 22, 80);
        cmp_got("t3_seq");
        step();
        chk("t3_busy", 32'(o_busy), 0);

        // 3b: last coinciding with the length cap releases once
        do_reset();
        for (int b = 1; b <= 16; b++) push(1, 8'(8'h80 + b), b == 16);
        run_until("t3b_len", 17, 60);
        step();
        step();
        chk("t3b_busy", 32'(o_busy), 0);
        chk("t3b_nohdr", 32'(got.size()), 17);

        // 4: backpressure during header and payload
        do_reset();
        push(3, 8'hC1, 0); push(3, 8'hC2, 0); push(3, 8'hC3, 1);
        step();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hdr", {o_valid, o_ready, o_out}, {1'b1, 4'b0000, 8'hA3});
        end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_pay", {o_valid, o_ready, o_out}, {1'b1, 4'b0000, 8'hC1});
        end
        rdy = 1'b1;
        run_until("t4_len", 4, 20);
        exp_q = '{8'hA3, 8'hC1, 8'hC2, 8'hC3};
        cmp_got("t4_seq");
        chk("t4_cnt", 32'(got.size()), 4);

        // 5: reset mid-payload of src1; src0 wins afterwards
        do_reset();
        for (int b = 1; b <= 5; b++) push(1, 8'(8'h50 + b), b == 5);
        for (int k = 0; k < 4; k++) step();
        exp_q = '{8'hA1, 8'h51, 8'h52};
        cmp_got("t5_pre");
        push(0, 8'h77, 1);
        rst_q = 1'b1; rdy = 1'b0;
        step();
        rst_q = 1'b0; rdy = 1'b1;
        got.delete();
        step();
        chk("t5_rst", {o_valid, o_ready, o_busy, o_gid}, 0);
        run_until("t5_len", 6, 40);
        exp_q = '{8'hA0, 8'h77, 8'hA1, 8'h53, 8'h54, 8'h55};
        cmp_got("t5_seq");

        // 6: header-less instance, src3 and src1 requesting together
        sel = 1'b1;
        do_reset();
        push(3, 8'h3C, 1);
        push(1, 8'h1C, 1);
        run_until("t6_len", 2, 20);
        exp_q = '{8'h1C, 8'h3C};
        cmp_got("t6_seq");
        chk("t6_gid", 32'(o_gid), 3);
        step();
        step();
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_cnt", 32'(got.size()), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
